// File: rtl/mem_console_pkg.sv
// Shared constants and types for the memory/console responder.
// Holds the console address, FSM state encoding and address-region decode.
// Pure declarations; no timing or flow control of its own.
package mem_console_pkg;

    localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;

    // FSM state type; encodings kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Address region selected by a transfer.
    typedef logic [1:0] region_t;
    localparam region_t REGION_RAM = 2'd0;
    localparam region_t REGION_CON = 2'd1;
    localparam region_t REGION_OOR = 2'd2;

    // RAM takes priority; the console is a single exact byte address.
    function automatic region_t decode_region(input logic [31:0] addr,
                                              input logic [31:0] words);
        if ({2'b00, addr[31:2]} < words)
            return REGION_RAM;
        else if (addr == CONSOLE_ADDR)
            return REGION_CON;
        else
            return REGION_OOR;
    endfunction

endpackage

// File: rtl/mem_console_responder_byte_fifo.sv
// Generic byte FIFO with occupancy count and registered head pointer.
// Latency: a pushed byte is visible at head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller watches full.
module byte_fifo #(
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [7:0]    head
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head reads as zero when empty so the console output is clean after reset.
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage is left unreset; only occupancy defines validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_console_responder.sv
// Native memory-bus responder: word RAM plus a console byte FIFO at CONSOLE_ADDR.
// Latency: mem_ready pulses WAIT_STATES+2 cycles after mem_valid is first sampled.
// Backpressure: console writes hold in WAIT while the FIFO is full; FIFO drains on con_valid&con_ready.
module mem_console_responder
    import mem_console_pkg::*;
#(
    parameter int MEM_WORDS   = 16384,
    parameter int WAIT_STATES = 0,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        err
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state_q;
    logic [3:0]    wait_cnt_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   ram [MEM_WORDS];

    region_t       region;
    logic          is_write;
    logic          stall;
    logic          go_resp;
    logic          in_resp;
    logic [AW-1:0] ram_idx;
    logic [31:0]   free_cnt;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;

    // Instruction-fetch flag carries no behaviour here.
    logic          unused_instr;
    assign unused_instr = mem_instr;

    // The request is latched on acceptance so the commit in RESP does not
    // depend on the CPU still holding the bus after it sees mem_ready.
    assign region   = decode_region(addr_q, 32'(MEM_WORDS));
    assign is_write = (wstrb_q != 4'h0);
    assign ram_idx  = addr_q[AW+1:2];
    assign in_resp  = (state_q == ST_RESP);
    assign stall    = (region == REGION_CON) && is_write && fifo_full;
    assign go_resp  = (state_q == ST_WAIT) && mem_valid && (wait_cnt_q == 4'd0) && !stall;
    assign free_cnt = 32'(FIFO_DEPTH) - 32'(fifo_count);

    assign fifo_push = in_resp && (region == REGION_CON) && is_write;
    assign fifo_pop  = con_valid && con_ready;

    assign mem_ready = in_resp;
    assign mem_rdata = rdata_q;
    assign con_valid = !fifo_empty;
    assign con_data  = fifo_head;
    assign err       = err_q;

    // Transfer FSM: accept, count wait states (holding on a full FIFO), respond once.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_valid) begin
                        state_q    <= ST_WAIT;
                        wait_cnt_q <= 4'(WAIT_STATES);
                        addr_q     <= mem_addr;
                        wdata_q    <= mem_wdata;
                        wstrb_q    <= mem_wstrb;
                    end
                end
                ST_WAIT: begin
                    if (!mem_valid)
                        state_q <= ST_IDLE;
                    else if (go_resp)
                        state_q <= ST_RESP;
                    else if (wait_cnt_q != 4'd0)
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read data is captured entering RESP and is zero in every other cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q <= 32'h0;
        end else if (go_resp && !is_write) begin
            case (region)
                REGION_RAM: rdata_q <= ram[ram_idx];
                REGION_CON: rdata_q <= {24'h0, free_cnt[7:0]};
                default:    rdata_q <= 32'h0;
            endcase
        end else begin
            rdata_q <= 32'h0;
        end
    end

    // Sticky out-of-range flag, raised when such an access completes.
    always_ff @(posedge clk) begin
        if (!resetn)
            err_q <= 1'b0;
        else if (in_resp && (region == REGION_OOR))
            err_q <= 1'b1;
    end

    // RAM byte-lane write at the end of RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (resetn && in_resp && (region == REGION_RAM) && is_write) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i])
                    ram[ram_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (fifo_push),
        .push_data(wdata_q[7:0]),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head     (fifo_head)
    );

endmodule
